// File: rtl/uart_baud_pkg.sv
// Shared baud-rate constants and the divisor function for the UART baud generator.
// Indices 6 and 7 are invalid and fall back to the 115200 entry.
package uart_baud_pkg;

  localparam logic [2:0] BAUD_1200   = 3'd0;
  localparam logic [2:0] BAUD_9600   = 3'd1;
  localparam logic [2:0] BAUD_19200  = 3'd2;
  localparam logic [2:0] BAUD_38400  = 3'd3;
  localparam logic [2:0] BAUD_57600  = 3'd4;
  localparam logic [2:0] BAUD_115200 = 3'd5;

  localparam int unsigned BAUD_RATE [0:7] = '{
    1200, 9600, 19200, 38400, 57600, 115200, 115200, 115200
  };

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= BAUD_115200);
  endfunction

  // Divisor rounded to the nearest integer clock count per bit.
  function automatic int unsigned baud_div(input logic [2:0] sel, input int unsigned clk_hz);
    int unsigned baud;
    baud = BAUD_RATE[sel];
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// One baud channel: latches its divisor on enable rise, counts, and emits a
// registered tick at a compare point (midpoint when MIDPOINT=1, else period end).
module uart_baud_chan
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned CNT_W    = 16,
  parameter bit          MIDPOINT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic       tick_o,
  output logic       start_o
);

  localparam logic [CNT_W-1:0] DIV_LUT [0:7] = '{
    CNT_W'(baud_div(3'd0, CLK_HZ)), CNT_W'(baud_div(3'd1, CLK_HZ)),
    CNT_W'(baud_div(3'd2, CLK_HZ)), CNT_W'(baud_div(3'd3, CLK_HZ)),
    CNT_W'(baud_div(3'd4, CLK_HZ)), CNT_W'(baud_div(3'd5, CLK_HZ)),
    CNT_W'(baud_div(3'd6, CLK_HZ)), CNT_W'(baud_div(3'd7, CLK_HZ))
  };
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(baud_div(BAUD_115200, CLK_HZ));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             en_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cmp;
  logic             tick_q, tick_d;

  assign start_o = en_i & ~en_q;
  assign cmp     = MIDPOINT ? (div_q >> 1) : (div_q - ONE);

  // The rise edge itself counts as the first counting edge, so cnt equals the edge index.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (start_o) begin
      div_d = DIV_LUT[sel_i];
      cnt_d = ONE;
    end else begin
      cnt_d  = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
      tick_d = (cnt_q == cmp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      cnt_q  <= '0;
      div_q  <= DIV_RST;
      tick_q <= 1'b0;
    end else begin
      en_q   <= en_i;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator top: independent TX (bit boundary) and RX (bit midpoint) channels.
// Optional RX 16x oversample tick enabled by defining UART_OVERSAMPLE_EN.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_sel,
  input  logic       tx_en,
  input  logic       rx_en,
  output logic       tx_tick,
  output logic       rx_tick,
  output logic       os_tick,
  output logic       sel_err
);

  localparam int unsigned MAX_DIV = baud_div(BAUD_1200, CLK_HZ);

  if (longint'(MAX_DIV) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for the largest baud divisor");
  end

  logic tx_start, rx_start;
  logic sel_err_q, sel_err_d;

  uart_baud_chan #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .MIDPOINT(1'b0)) u_tx (
    .clk(clk), .rst(rst), .en_i(tx_en), .sel_i(baud_sel),
    .tick_o(tx_tick), .start_o(tx_start)
  );

  uart_baud_chan #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .MIDPOINT(1'b1)) u_rx (
    .clk(clk), .rst(rst), .en_i(rx_en), .sel_i(baud_sel),
    .tick_o(rx_tick), .start_o(rx_start)
  );

  // Both channels sample the same baud_sel on a given edge, so one flag covers both.
  always_comb begin
    sel_err_d = sel_err_q;
    if (tx_start || rx_start) begin
      sel_err_d = ~sel_valid(baud_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef UART_OVERSAMPLE_EN
  localparam logic [CNT_W-1:0] OS_LUT [0:7] = '{
    CNT_W'(baud_div(3'd0, CLK_HZ) / 16), CNT_W'(baud_div(3'd1, CLK_HZ) / 16),
    CNT_W'(baud_div(3'd2, CLK_HZ) / 16), CNT_W'(baud_div(3'd3, CLK_HZ) / 16),
    CNT_W'(baud_div(3'd4, CLK_HZ) / 16), CNT_W'(baud_div(3'd5, CLK_HZ) / 16),
    CNT_W'(baud_div(3'd6, CLK_HZ) / 16), CNT_W'(baud_div(3'd7, CLK_HZ) / 16)
  };
  localparam logic [CNT_W-1:0] OS_RST = CNT_W'(baud_div(BAUD_115200, CLK_HZ) / 16);
  localparam logic [CNT_W-1:0] OS_ONE = CNT_W'(1);

  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic [CNT_W-1:0] os_div_q, os_div_d;
  logic             os_tick_q, os_tick_d;

  // Oversample divisor is latched alongside the RX divisor so both restart in phase.
  always_comb begin
    os_cnt_d  = os_cnt_q;
    os_div_d  = os_div_q;
    os_tick_d = 1'b0;
    if (!rx_en) begin
      os_cnt_d = '0;
    end else if (rx_start) begin
      os_div_d = OS_LUT[baud_sel];
      os_cnt_d = OS_ONE;
    end else begin
      os_cnt_d  = (os_cnt_q == os_div_q - OS_ONE) ? '0 : os_cnt_q + OS_ONE;
      os_tick_d = (os_cnt_q == os_div_q - OS_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt_q  <= '0;
      os_div_q  <= OS_RST;
      os_tick_q <= 1'b0;
    end else begin
      os_cnt_q  <= os_cnt_d;
      os_div_q  <= os_div_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign os_tick = os_tick_q;
`else
  assign os_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed testbench for uart_baud_gen at 50 MHz; edge numbers count from the
// first clock edge that samples the enable high.
module tb_uart_baud_gen;

  logic       clk;
  logic       rst;
  logic [2:0] baud_sel;
  logic       tx_en;
  logic       rx_en;
  logic       tx_tick;
  logic       rx_tick;
  logic       os_tick;
  logic       sel_err;

  int nRun  = 0;
  int nFail = 0;

  int mCount [3];
  int mFirst [3];
  int mSecond[3];
  int mEarly [3];

`ifdef UART_OVERSAMPLE_EN
  localparam bit OS_ON = 1'b1;
`else
  localparam bit OS_ON = 1'b0;
`endif

  uart_baud_gen #(.CLK_HZ(50_000_000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .tx_en(tx_en), .rx_en(rx_en),
    .tx_tick(tx_tick), .rx_tick(rx_tick), .os_tick(os_tick), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs n edges, sampling 1 ns after each; index 0=tx, 1=rx, 2=os.
  task automatic measure(input int n, input int early);
    logic s [3];
    for (int k = 0; k < 3; k++) begin
      mCount[k] = 0; mFirst[k] = 0; mSecond[k] = 0; mEarly[k] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      s[0] = tx_tick; s[1] = rx_tick; s[2] = os_tick;
      for (int k = 0; k < 3; k++) begin
        if (s[k]) begin
          mCount[k]++;
          if (i <= early) mEarly[k]++;
          if (mCount[k] == 1) mFirst[k] = i;
          else if (mCount[k] == 2) mSecond[k] = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; baud_sel = 3'd5; tx_en = 1'b0; rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nRun++; if (tx_tick !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tx_tick got %b want 0", tx_tick); end
    nRun++; if (rx_tick !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rx_tick got %b want 0", rx_tick); end
    nRun++; if (os_tick !== 1'b0) begin nFail++; $display("[TB] FAIL reset_os_tick got %b want 0", os_tick); end
    nRun++; if (sel_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_sel_err got %b want 0", sel_err); end
    nRun++; if (dut.u_tx.div_q !== 16'd434) begin nFail++; $display("[TB] FAIL reset_tx_div got %0d want 434", dut.u_tx.div_q); end
    nRun++; if (dut.u_rx.cnt_q !== 16'd0) begin nFail++; $display("[TB] FAIL reset_rx_cnt got %0d want 0", dut.u_rx.cnt_q); end
    rst = 1'b0;
    measure(5, 0);
    nRun++; if (mCount[0] + mCount[1] + mCount[2] !== 0) begin nFail++; $display("[TB] FAIL idle_ticks got %0d want 0", mCount[0] + mCount[1] + mCount[2]); end
  endtask

  task automatic test_rx_115200();
    baud_sel = 3'd5; rx_en = 1'b1;
    measure(900, 434);
    nRun++; if (mFirst[1] !== 218) begin nFail++; $display("[TB] FAIL rx115k_first got %0d want 218", mFirst[1]); end
    nRun++; if (mSecond[1] !== 652) begin nFail++; $display("[TB] FAIL rx115k_second got %0d want 652", mSecond[1]); end
    nRun++; if (mCount[1] !== 2) begin nFail++; $display("[TB] FAIL rx115k_count got %0d want 2", mCount[1]); end
    nRun++; if (mCount[0] !== 0) begin nFail++; $display("[TB] FAIL rx115k_tx_quiet got %0d want 0", mCount[0]); end
    nRun++; if (mFirst[2] !== (OS_ON ? 27 : 0)) begin nFail++; $display("[TB] FAIL os_first got %0d want %0d", mFirst[2], OS_ON ? 27 : 0); end
    nRun++; if (mSecond[2] !== (OS_ON ? 54 : 0)) begin nFail++; $display("[TB] FAIL os_second got %0d want %0d", mSecond[2], OS_ON ? 54 : 0); end
    nRun++; if (mEarly[2] !== (OS_ON ? 16 : 0)) begin nFail++; $display("[TB] FAIL os_in_434 got %0d want %0d", mEarly[2], OS_ON ? 16 : 0); end
    nRun++; if (mCount[2] !== (OS_ON ? 33 : 0)) begin nFail++; $display("[TB] FAIL os_count got %0d want %0d", mCount[2], OS_ON ? 33 : 0); end
    rx_en = 1'b0;
    measure(2, 0);
  endtask

  task automatic test_rx_drop();
    baud_sel = 3'd5; rx_en = 1'b1;
    measure(217, 0);
    nRun++; if (mCount[1] !== 0) begin nFail++; $display("[TB] FAIL drop_pre got %0d want 0", mCount[1]); end
    rx_en = 1'b0;
    measure(500, 0);
    nRun++; if (mCount[1] !== 0) begin nFail++; $display("[TB] FAIL drop_no_pulse got %0d want 0", mCount[1]); end
    nRun++; if (mCount[2] !== 0) begin nFail++; $display("[TB] FAIL drop_os_quiet got %0d want 0", mCount[2]); end
    rx_en = 1'b1;
    measure(300, 0);
    nRun++; if (mFirst[1] !== 218) begin nFail++; $display("[TB] FAIL drop_restart got %0d want 218", mFirst[1]); end
    rx_en = 1'b0;
    measure(2, 0);
  endtask

  task automatic test_sel_err();
    baud_sel = 3'd7; rx_en = 1'b1;
    measure(900, 0);
    nRun++; if (sel_err !== 1'b1) begin nFail++; $display("[TB] FAIL selerr_set got %b want 1", sel_err); end
    nRun++; if (mSecond[1] - mFirst[1] !== 434) begin nFail++; $display("[TB] FAIL selerr_period got %0d want 434", mSecond[1] - mFirst[1]); end
    rx_en = 1'b0;
    measure(2, 0);
    baud_sel = 3'd1; rx_en = 1'b1;
    measure(8000, 0);
    nRun++; if (sel_err !== 1'b0) begin nFail++; $display("[TB] FAIL selerr_clear got %b want 0", sel_err); end
    nRun++; if (mFirst[1] !== 2605) begin nFail++; $display("[TB] FAIL rx9600_first got %0d want 2605", mFirst[1]); end
    nRun++; if (mSecond[1] - mFirst[1] !== 5208) begin nFail++; $display("[TB] FAIL rx9600_period got %0d want 5208", mSecond[1] - mFirst[1]); end
    rx_en = 1'b0;
    measure(2, 0);
  endtask

  task automatic test_tx_1200();
    baud_sel = 3'd0; tx_en = 1'b1;
    measure(100, 0);
    nRun++; if (mCount[0] !== 0) begin nFail++; $display("[TB] FAIL tx1200_early got %0d want 0", mCount[0]); end
    baud_sel = 3'd5;
    measure(41600, 0);
    nRun++; if (mFirst[0] !== 41567) begin nFail++; $display("[TB] FAIL tx1200_first got %0d want 41567", mFirst[0]); end
    nRun++; if (mCount[0] !== 1) begin nFail++; $display("[TB] FAIL tx1200_count got %0d want 1", mCount[0]); end
    nRun++; if (mCount[1] + mCount[2] !== 0) begin nFail++; $display("[TB] FAIL tx1200_rx_quiet got %0d want 0", mCount[1] + mCount[2]); end
    tx_en = 1'b0;
    measure(2, 0);
  endtask

  task automatic test_both();
    baud_sel = 3'd1; tx_en = 1'b1; rx_en = 1'b1;
    measure(5300, 0);
    nRun++; if (mFirst[0] !== 5208) begin nFail++; $display("[TB] FAIL both_tx_first got %0d want 5208", mFirst[0]); end
    nRun++; if (mFirst[1] !== 2605) begin nFail++; $display("[TB] FAIL both_rx_first got %0d want 2605", mFirst[1]); end
    nRun++; if (mCount[0] !== 1) begin nFail++; $display("[TB] FAIL both_tx_count got %0d want 1", mCount[0]); end
    tx_en = 1'b0; rx_en = 1'b0;
    measure(2, 0);
  endtask

  task automatic test_reset_async();
    baud_sel = 3'd7; tx_en = 1'b1;
    measure(434, 0);
    nRun++; if (tx_tick !== 1'b1) begin nFail++; $display("[TB] FAIL async_pre_tick got %b want 1", tx_tick); end
    nRun++; if (sel_err !== 1'b1) begin nFail++; $display("[TB] FAIL async_pre_err got %b want 1", sel_err); end
    #1 rst = 1'b1;
    #1;
    nRun++; if (tx_tick !== 1'b0) begin nFail++; $display("[TB] FAIL async_tick_drop got %b want 0", tx_tick); end
    nRun++; if (sel_err !== 1'b0) begin nFail++; $display("[TB] FAIL async_sel_err got %b want 0", sel_err); end
    nRun++; if (dut.u_tx.cnt_q !== 16'd0) begin nFail++; $display("[TB] FAIL async_tx_cnt got %0d want 0", dut.u_tx.cnt_q); end
    nRun++; if (dut.u_rx.div_q !== 16'd434) begin nFail++; $display("[TB] FAIL async_rx_div got %0d want 434", dut.u_rx.div_q); end
    @(posedge clk);
    #1;
    rst = 1'b0; baud_sel = 3'd5;
    measure(434, 0);
    nRun++; if (mFirst[0] !== 434) begin nFail++; $display("[TB] FAIL post_rst_tx_first got %0d want 434", mFirst[0]); end
    nRun++; if (sel_err !== 1'b0) begin nFail++; $display("[TB] FAIL post_rst_sel_err got %b want 0", sel_err); end
    tx_en = 1'b0;
    measure(2, 0);
  endtask

  initial begin
    test_reset();
    test_rx_115200();
    test_rx_drop();
    test_sel_err();
    test_tx_1200();
    test_both();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the divider counter width; elaboration SHALL fail if 2**CNT_W is not greater than the largest divisor.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port baud_sel, input, 3 bits: baud index. 0=1200, 1=9600, 2=19200, 3=38400, 4=57600, 5=115200, 6/7 invalid.
REQ-006 SHALL have port tx_en, input, 1 bit: TX channel run enable.
REQ-007 SHALL have port rx_en, input, 1 bit: RX channel run enable.
REQ-008 SHALL have port tx_tick, output, 1 bit: one-cycle pulse at each TX bit boundary.
REQ-009 SHALL have port rx_tick, output, 1 bit: one-cycle pulse at each RX bit midpoint.
REQ-010 SHALL have port os_tick, output, 1 bit: one-cycle RX 16x oversample pulse.
REQ-011 SHALL have port sel_err, output, 1 bit: registered flag meaning the last latched baud_sel was invalid.

Function
REQ-012 SHALL compute DIV(sel) = (CLK_HZ + baud/2) / baud as an integer (e.g. 434 for 115200 and 41667 for 1200 at 50 MHz), and HALF = DIV/2 with floor.
REQ-013 SHALL give each channel its own counter cnt[CNT_W-1:0] and its own latched divisor div_q.
REQ-014 On the clock edge where en rises from 0 to 1, each channel SHALL latch DIV(baud_sel) into div_q; changes to baud_sel while en is high SHALL be ignored.
REQ-015 baud_sel 6 or 7 SHALL latch DIV for 115200 and set sel_err; a valid latch by either channel SHALL clear sel_err.
REQ-016 While en is low, cnt SHALL be held at 0 and that channel's ticks SHALL be 0.
REQ-017 While en is high, cnt SHALL increment by 1 per clock and wrap from div_q-1 to 0.
REQ-018 rx_tick SHALL be registered and assert for exactly one cycle on the edge after cnt==HALF.
- The first pulse is at the (HALF+1)th edge with rx_en high.
- The period thereafter is div_q cycles.
REQ-019 tx_tick SHALL be registered and assert for exactly one cycle on the edge after cnt==div_q-1.
- The first pulse is at the div_q-th edge with tx_en high.
REQ-020 Deassertion of en SHALL zero cnt and the tick on the next edge, with no further pulse; reasserting en SHALL restart phase exactly as in REQ-018/REQ-019.
REQ-021 The channels SHALL be fully independent; simultaneous enables with different baud_sel values are not possible (the sel is sampled once per edge), and both latch the same value.

Reset
REQ-022 When rst is high, SHALL asynchronously force:
- cnt to 0 in both channels;
- div_q to DIV(115200);
- tx_tick, rx_tick, os_tick and sel_err to 0.
REQ-023 Reset asserted mid-period SHALL drop any active tick immediately.
REQ-024 After rst is released, a channel whose en is already high SHALL latch baud_sel on the first clock edge and start counting from 0.

Configuration
REQ-025 With macro UART_OVERSAMPLE_EN defined, the RX channel SHALL run a second counter with OS_DIV = div_q/16 (floor; 27 at 115200).
- os_tick SHALL pulse one cycle every OS_DIV cycles while rx_en is high.
- Its phase SHALL restart on rx_en rise.
- It SHALL be held at 0 while rx_en is low.
REQ-026 Without UART_OVERSAMPLE_EN, os_tick SHALL be tied to 0 and no oversample counter SHALL be synthesised.

Structure
REQ-027 Package uart_baud_pkg SHALL hold:
- the baud index constants;
- the baud rate table;
- a constant function returning DIV for a given (sel, CLK_HZ).
REQ-028 A sub-module uart_baud_chan (one counter, one latched divisor, one compare-tick output with selectable compare point HALF or div_q-1) SHALL be instantiated twice.

Verification (all at CLK_HZ = 50 MHz)
REQ-029 baud_sel=5, rx_en rises:
- rx_tick first at edge 218, then every 434 cycles;
- tx_tick stays 0.
REQ-030 baud_sel=0, tx_en rises:
- tx_tick at edges 41667, 83334, ...;
- baud_sel changed to 5 mid-run has no effect.
REQ-031 baud_sel=7, rx_en rises:
- sel_err=1 and rx_tick period is 434;
- then rx_en low, baud_sel=1, rx_en high gives sel_err=0 and a period of 5208.
REQ-032 rx_en is dropped one cycle before an expected rx_tick:
- no pulse occurs;
- re-enabling gives the first pulse again at HALF+1.
REQ-033 rst is pulsed asynchronously while tx_tick is high:
- the tick drops without waiting for a clock edge;
- counters and sel_err are 0;
- div_q equals 434.
REQ-034 With UART_OVERSAMPLE_EN, baud_sel=5, rx_en high:
- os_tick period is 27;
- 16 os_ticks fall within the first 434 cycles;
- without the macro, os_tick stays 0.
